// File: rtl/mux_serializer_seq.sv
// Load/stream sequencer wrapped around an external 16:1 mux: latches a word onto the
// mux inputs, walks the select, streams the returned bits and loop-checks them.
module mux_serializer_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [15:0] mux_in,
  output logic [3:0]  mux_sel,
  input  logic        mux_out,
  output logic        ser_valid,
  output logic        ser_data,
  output logic        ser_last,
  input  logic        ser_ready,
  input  logic        abort,
  input  logic        err_clr,
  output logic        err
);

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [SW-1:0] FIRST_SEL = MSB_FIRST ? SW'(W - 1) : SW'(0);
  localparam logic [SW-1:0] LAST_SEL  = MSB_FIRST ? SW'(0) : SW'(W - 1);

  logic [0:0]    state, state_nx;
  logic [W-1:0]  shadow, shadow_nx;
  logic [W-1:0]  mux_in_nx;
  logic [SW-1:0] sel_nx;
  logic          err_nx;
  logic          load_ready_nx, ser_valid_nx, ser_last_nx;
  logic          accept, mismatch;

  // Returned mux bit goes straight out; select/inputs only move on load or accept.
  assign ser_data = mux_out;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mux_in     <= '0;
      shadow     <= '0;
      mux_sel    <= '0;
      err        <= 1'b0;
      load_ready <= 1'b1;
      ser_valid  <= 1'b0;
      ser_last   <= 1'b0;
    end else begin
      state      <= state_nx;
      mux_in     <= mux_in_nx;
      shadow     <= shadow_nx;
      mux_sel    <= sel_nx;
      err        <= err_nx;
      load_ready <= load_ready_nx;
      ser_valid  <= ser_valid_nx;
      ser_last   <= ser_last_nx;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_nx  = state;
    mux_in_nx = mux_in;
    shadow_nx = shadow;
    sel_nx    = mux_sel;
    accept    = 1'b0;
    mismatch  = 1'b0;

    case (state)
      IDLE: begin
        if (load_valid) begin
          state_nx  = SHIFT;
          mux_in_nx = load_data;
          shadow_nx = load_data;
          sel_nx    = FIRST_SEL;
        end
      end
      SHIFT: begin
        accept   = ser_ready;
        mismatch = accept && (mux_out != shadow[mux_sel]);
        // abort wins over stepping and over the last-bit exit; select is frozen
        if (abort) begin
          state_nx = IDLE;
        end else if (accept) begin
          if (mux_sel == LAST_SEL) begin
            state_nx = IDLE;
          end else if (MSB_FIRST) begin
            sel_nx = mux_sel - SW'(1);
          end else begin
            sel_nx = mux_sel + SW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // A new mismatch beats a simultaneous clear.
    err_nx        = mismatch | (err & ~err_clr);
    load_ready_nx = (state_nx == IDLE);
    ser_valid_nx  = (state_nx == SHIFT);
    ser_last_nx   = (state_nx == SHIFT) && (sel_nx == LAST_SEL);
  end

endmodule

// File: tb/tb_mux_serializer_seq.sv
// Runs LSB-first and MSB-first instances in lockstep, with the mux modelled as a bit
// pick from mux_in, and checks both against a per-word bit-sequence model.
module tb_mux_serializer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [15:0] load_data;
  logic        ser_ready;
  logic        abort;
  logic        err_clr;
  logic [1:0]  inj;

  logic        load_ready0, load_ready1;
  logic [15:0] mux_in0, mux_in1;
  logic [3:0]  mux_sel0, mux_sel1;
  logic        mux_out0, mux_out1;
  logic        ser_valid0, ser_valid1;
  logic        ser_data0, ser_data1;
  logic        ser_last0, ser_last1;
  logic        err0, err1;

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_err = 1'b0;
  bit rdy_q[$];

  always #5 clk = ~clk;

  // Behavioural 16:1 mux with optional bit inversion to provoke loopback errors
  assign mux_out0 = mux_in0[mux_sel0] ^ inj[0];
  assign mux_out1 = mux_in1[mux_sel1] ^ inj[1];

  mux_serializer_seq #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready0), .mux_in(mux_in0), .mux_sel(mux_sel0), .mux_out(mux_out0),
    .ser_valid(ser_valid0), .ser_data(ser_data0), .ser_last(ser_last0),
    .ser_ready(ser_ready), .abort(abort), .err_clr(err_clr), .err(err0)
  );

  mux_serializer_seq #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready1), .mux_in(mux_in1), .mux_sel(mux_sel1), .mux_out(mux_out1),
    .ser_valid(ser_valid1), .ser_data(ser_data1), .ser_last(ser_last1),
    .ser_ready(ser_ready), .abort(abort), .err_clr(err_clr), .err(err1)
  );

  `define CHK(tag, obs, expv) \
    begin \
      n_chk++; \
      assert ((obs) === (expv)) else begin \
        n_fail++; \
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv); \
      end \
    end

  task automatic check_idle(input logic [15:0] w, input logic [3:0] s0, input logic [3:0] s1);
    `CHK("idle_load_ready0", load_ready0, 1'b1)
    `CHK("idle_load_ready1", load_ready1, 1'b1)
    `CHK("idle_ser_valid0", ser_valid0, 1'b0)
    `CHK("idle_ser_valid1", ser_valid1, 1'b0)
    `CHK("idle_ser_last0", ser_last0, 1'b0)
    `CHK("idle_ser_last1", ser_last1, 1'b0)
    `CHK("idle_mux_in0", mux_in0, w)
    `CHK("idle_mux_in1", mux_in1, w)
    `CHK("idle_sel0", mux_sel0, s0)
    `CHK("idle_sel1", mux_sel1, s1)
    `CHK("idle_err0", err0, exp_err)
    `CHK("idle_err1", err1, exp_err)
  endtask

  // Reset-state check of every output of both instances
  task automatic check_reset_state(input string tag);
    n_chk++;
    if (load_ready0 !== 1'b1 || load_ready1 !== 1'b1 ||
        ser_valid0 !== 1'b0 || ser_valid1 !== 1'b0 ||
        ser_last0 !== 1'b0 || ser_last1 !== 1'b0 ||
        mux_in0 !== 16'h0000 || mux_in1 !== 16'h0000 ||
        mux_sel0 !== 4'h0 || mux_sel1 !== 4'h0 ||
        err0 !== 1'b0 || err1 !== 1'b0) begin
      n_fail++;
      $error("FAIL %s: outputs not at reset values (lr=%b%b sv=%b%b sl=%b%b in=%h/%h sel=%h/%h err=%b%b)",
             tag, load_ready0, load_ready1, ser_valid0, ser_valid1, ser_last0, ser_last1,
             mux_in0, mux_in1, mux_sel0, mux_sel1, err0, err1);
    end
  endtask

  // One word: bit k of the stream is w[k] (LSB-first) or w[15-k] (MSB-first).
  task automatic run_word(input logic [15:0] w, input int abort_at, input int inj_at,
                          input int clr_at, input bit rand_bp, input bit lv_pulse,
                          output int cycles, output int nacc);
    int k = 0;
    int last_k = 0;
    bit rdy, ab, ok;
    logic [3:0] i0, i1;
    cycles = 0;
    @(negedge clk);
    load_valid = 1'b1; load_data = w; ser_ready = 1'b1; abort = 1'b0; err_clr = 1'b0;
    inj = 2'b00;
    #1;
    `CHK("load_ready0", load_ready0, 1'b1)
    `CHK("load_ready1", load_ready1, 1'b1)
    @(posedge clk);
    forever begin
      @(negedge clk);
      cycles++;
      if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
      else if (rand_bp) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1'b1;
      ab = (k == abort_at);
      if (ab) rdy = 1'b1;
      load_valid = lv_pulse && (k < 10);
      load_data  = ~w;
      ser_ready  = rdy;
      abort      = ab;
      err_clr    = (k == clr_at);
      inj        = (k == inj_at) ? 2'b11 : 2'b00;
      i0 = 4'(k);
      i1 = 4'(15 - k);
      #1;
      `CHK("ser_valid0", ser_valid0, 1'b1)
      `CHK("ser_valid1", ser_valid1, 1'b1)
      `CHK("busy_load_ready0", load_ready0, 1'b0)
      `CHK("busy_load_ready1", load_ready1, 1'b0)
      `CHK("ser_last0", ser_last0, (k == 15))
      `CHK("ser_last1", ser_last1, (k == 15))
      `CHK("sel0", mux_sel0, i0)
      `CHK("sel1", mux_sel1, i1)
      `CHK("ser_data0", ser_data0, w[i0] ^ inj[0])
      `CHK("ser_data1", ser_data1, w[i1] ^ inj[1])
      `CHK("mux_in0", mux_in0, w)
      `CHK("mux_in1", mux_in1, w)
      `CHK("err0", err0, exp_err)
      `CHK("err1", err1, exp_err)
      @(posedge clk);
      if (rdy && (k == inj_at)) exp_err = 1'b1;
      else if (k == clr_at) exp_err = 1'b0;
      last_k = k;
      if (rdy) k++;
      if (ab || k == 16 || cycles > 200) break;
    end
    ok = (cycles <= 200);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL no_timeout: word %h did not complete within 200 cycles (bits=%0d)", w, k);
    end
    @(negedge clk);
    load_valid = 1'b0; ser_ready = 1'b1; abort = 1'b0; err_clr = 1'b0; inj = 2'b00;
    #1;
    check_idle(w, 4'(last_k), 4'(15 - last_k));
    nacc = k;
  endtask

  initial begin
    int cyc, nacc;
    logic [15:0] rw;
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; ser_ready = 1'b0;
    abort = 1'b0; err_clr = 1'b0; inj = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    check_idle(16'h0000, 4'h0, 4'h0);
    check_reset_state("initial_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // LSB-first / MSB-first plain streams
    run_word(16'hA5C3, -1, -1, -1, 1'b0, 1'b0, cyc, nacc);
    `CHK("a5c3_cycles", cyc, 16)
    `CHK("a5c3_bits", nacc, 16)
    run_word(16'h8001, -1, -1, -1, 1'b0, 1'b0, cyc, nacc);
    `CHK("8001_cycles", cyc, 16)

    // Stall 3 cycles at bit 5 and 1 cycle at bit 15, with load_valid pulsed while busy
    repeat (5) rdy_q.push_back(1'b1);
    repeat (3) rdy_q.push_back(1'b0);
    repeat (10) rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b1);
    run_word(16'hFFFF, -1, -1, -1, 1'b0, 1'b1, cyc, nacc);
    `CHK("bp_cycles", cyc, 20)
    `CHK("bp_bits", nacc, 16)

    // Abort while bit 7 is shown, then a normal word
    run_word(16'h1234, 7, -1, -1, 1'b0, 1'b0, cyc, nacc);
    `CHK("abort_bits", nacc, 8)
    `CHK("abort_cycles", cyc, 8)
    rw = 16'($urandom);
    run_word(rw, -1, -1, -1, 1'b0, 1'b0, cyc, nacc);
    `CHK("post_abort_cycles", cyc, 16)

    // Loopback mismatch on bit 3, clear in idle, then clear colliding with a mismatch
    run_word(16'h0F0F, -1, 3, -1, 1'b0, 1'b0, cyc, nacc);
    `CHK("mismatch_err0", err0, 1'b1)
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    #1;
    `CHK("clr_err0", err0, 1'b0)
    `CHK("clr_err1", err1, 1'b0)
    run_word(16'h3C3C, -1, 3, 3, 1'b0, 1'b0, cyc, nacc);
    `CHK("set_beats_clr0", err0, 1'b1)
    `CHK("set_beats_clr1", err1, 1'b1)

    // Randomized words with random backpressure and occasional faults
    for (int n = 0; n < 8; n++) begin
      rw = 16'($urandom);
      run_word(rw, -1, int'($urandom_range(0, 24)), int'($urandom_range(0, 24)),
               1'b1, 1'b0, cyc, nacc);
      `CHK("rand_bits", nacc, 16)
    end

    // Asynchronous reset mid-word, with err forced high first
    run_word(16'hFFFF, -1, 0, -1, 1'b0, 1'b0, cyc, nacc);
    @(negedge clk);
    load_valid = 1'b1; load_data = 16'($urandom);
    @(negedge clk);
    load_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_err = 1'b0;
    #1;
    check_idle(16'h0000, 4'h0, 4'h0);
    check_reset_state("midword_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_idle(16'h0000, 4'h0, 4'h0);
      check_reset_state("post_reset_release");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
